// File: rtl/mem_rd_arbiter_if.sv
// mem_rd_arbiter_if: request, response and RAM-port signals of the read arbiter
interface mem_rd_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*AW-1:0] req_addr_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [DW-1:0]      rsp_data_o;
    logic               mem_en_o;
    logic [AW-1:0]      mem_addr_o;
    logic [DW-1:0]      mem_data_i;
    logic               mem_valid_i;

    modport master (
        input  req_valid_i, req_addr_i, mem_data_i, mem_valid_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, mem_en_o, mem_addr_o
    );

    modport slave (
        output req_valid_i, req_addr_i, mem_data_i, mem_valid_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, mem_en_o, mem_addr_o
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: round-robin sharing of one RAM read port with an in-order tag FIFO (RD_ARB_BURST_EN enables burst grants)
module mem_rd_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    mem_rd_arbiter_if.master           bus,
    output logic [$clog2(DEPTH+1)-1:0] pending_o,
    output logic                       err_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_tag [DEPTH];
    logic [FW-1:0] r_head, r_tail;
    logic [CW-1:0] r_pending;
    logic          r_mem_en;
    logic [AW-1:0] r_mem_addr;
    logic          r_err;

    logic [PW-1:0] w_j, w_rr_idx, w_win;
    logic          w_rr_hit, w_burst, w_pop, w_can, w_grant;

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        w_j      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = PW'((int'(r_ptr) + k) % NREQ);
            if (bus.req_valid_i[w_j]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_j;
            end
        end
    end

`ifdef RD_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [PW-1:0] r_last;
    logic          r_last_v;
    logic [BW-1:0] r_cnt;

    assign w_burst = r_last_v && bus.req_valid_i[r_last] && (r_cnt < BW'(BURST_LEN - 1));
    assign w_win   = w_burst ? r_last : w_rr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= '0;
            r_last_v <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_last   <= w_win;
                r_last_v <= 1'b1;
            end
            r_cnt <= (w_grant && w_burst) ? r_cnt + 1'b1 : '0;
        end
    end
`else
    assign w_burst = BURST_LEN < 0;
    assign w_win   = w_rr_idx;
`endif

    assign w_pop   = !rst && bus.mem_valid_i && (r_pending != '0);
    assign w_can   = (r_pending < CW'(DEPTH)) || w_pop;
    assign w_grant = !rst && w_can && (w_burst || w_rr_hit);

    assign bus.req_ready_o = w_grant ? (NREQ'(1) << w_win) : '0;
    assign bus.rsp_valid_o = w_pop ? (NREQ'(1) << r_tag[r_head]) : '0;
    assign bus.rsp_data_o  = rst ? '0 : bus.mem_data_i;
    assign bus.mem_en_o    = r_mem_en;
    assign bus.mem_addr_o  = r_mem_addr;
    assign pending_o       = r_pending;
    assign err_o           = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_pending  <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_err      <= 1'b0;
        end else begin
            r_mem_en  <= w_grant;
            r_pending <= r_pending + CW'(w_grant) - CW'(w_pop);
            if (w_grant) begin
                r_mem_addr    <= bus.req_addr_i[w_win*AW +: AW];
                r_tag[r_tail] <= w_win;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_grant && !w_burst)
                r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            if (bus.mem_valid_i && !w_pop)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: vector table, burst/RR corner sequences and a queue-based random model
module tb_mem_rd_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pending;
    logic       err;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.NREQ(3), .AW(16), .DW(8)) bus ();

    mem_rd_arbiter #(.NREQ(3), .AW(16), .DW(8), .DEPTH(4), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .pending_o(pending), .err_o(err)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic        mv;
        logic [7:0]  md;
        logic [2:0]  rdy;
        logic [2:0]  rsp;
        logic [2:0]  pend;
        logic        en;
        logic [15:0] addr;
        logic        err;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] vl, input logic m, input logic [7:0] d,
                       input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] p,
                       input logic e, input logic [15:0] ad, input logic er);
        tab.push_back('{r, vl, m, d, rd, rs, p, e, ad, er});
    endtask

    task automatic run_row(input vec_t v, input int idx);
        rst             = v.rst;
        bus.req_valid_i = v.vld;
        bus.mem_valid_i = v.mv;
        bus.mem_data_i  = v.md;
        #1;
        chk($sformatf("ready[%0d]", idx), 32'(bus.req_ready_o), 32'(v.rdy));
        chk($sformatf("rsp_valid[%0d]", idx), 32'(bus.rsp_valid_o), 32'(v.rsp));
        chk($sformatf("rsp_data[%0d]", idx), 32'(bus.rsp_data_o), v.rst ? 32'd0 : 32'(v.md));
        @(posedge clk);
        #1;
        chk($sformatf("pending[%0d]", idx), 32'(pending), 32'(v.pend));
        chk($sformatf("mem_en[%0d]", idx), 32'(bus.mem_en_o), 32'(v.en));
        chk($sformatf("mem_addr[%0d]", idx), 32'(bus.mem_addr_o), 32'(v.addr));
        chk($sformatf("err[%0d]", idx), 32'(err), 32'(v.err));
    endtask

    initial begin
        logic [15:0] a[3];
        logic [2:0]  v;
        logic        mv, pop, can, g;
        logic [7:0]  md;
        logic [2:0]  erdy, ersp;
        logic [15:0] last_addr;
        int          tq[$];
        logic [7:0]  ram_q[$];
        int          ptr, win;

        bus.req_addr_i  = {16'h0030, 16'h0020, 16'h0010};
        bus.req_valid_i = '0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i  = '0;

        add(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
        add(0, 3'b001, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b000, 1, 8'hA5, 3'b000, 3'b001, 0, 0, 16'h0010, 0);
        add(1, 3'b011, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
        add(0, 3'b001, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b010, 0, 8'h00, 3'b010, 3'b000, 2, 1, 16'h0020, 0);
        add(1, 3'b011, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
        add(0, 3'b000, 1, 8'h5A, 3'b000, 3'b000, 0, 0, 16'h0000, 1);
        add(0, 3'b011, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 1);
        add(0, 3'b000, 1, 8'hC3, 3'b000, 3'b001, 0, 0, 16'h0010, 1);
        add(0, 3'b000, 1, 8'h3C, 3'b000, 3'b000, 0, 0, 16'h0010, 1);
        add(1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
`ifndef RD_ARB_BURST_EN
        add(0, 3'b111, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b111, 1, 8'h11, 3'b010, 3'b001, 1, 1, 16'h0020, 0);
        add(0, 3'b111, 1, 8'h22, 3'b100, 3'b010, 1, 1, 16'h0030, 0);
        add(0, 3'b111, 1, 8'h33, 3'b001, 3'b100, 1, 1, 16'h0010, 0);
        add(0, 3'b111, 1, 8'h44, 3'b010, 3'b001, 1, 1, 16'h0020, 0);
        add(0, 3'b111, 1, 8'h55, 3'b100, 3'b010, 1, 1, 16'h0030, 0);
        add(0, 3'b000, 1, 8'h66, 3'b000, 3'b100, 0, 0, 16'h0030, 0);
        add(1, 3'b111, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
        add(0, 3'b111, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b111, 0, 8'h00, 3'b010, 3'b000, 2, 1, 16'h0020, 0);
        add(0, 3'b111, 0, 8'h00, 3'b100, 3'b000, 3, 1, 16'h0030, 0);
        add(0, 3'b111, 0, 8'h00, 3'b001, 3'b000, 4, 1, 16'h0010, 0);
        add(0, 3'b111, 0, 8'h00, 3'b000, 3'b000, 4, 0, 16'h0010, 0);
        add(0, 3'b111, 1, 8'h77, 3'b010, 3'b001, 4, 1, 16'h0020, 0);
        add(0, 3'b000, 1, 8'h88, 3'b000, 3'b010, 3, 0, 16'h0020, 0);
`else
        add(0, 3'b011, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b011, 1, 8'h11, 3'b001, 3'b001, 1, 1, 16'h0010, 0);
        add(0, 3'b011, 1, 8'h11, 3'b001, 3'b001, 1, 1, 16'h0010, 0);
        add(0, 3'b011, 1, 8'h11, 3'b001, 3'b001, 1, 1, 16'h0010, 0);
        add(0, 3'b011, 1, 8'h11, 3'b010, 3'b001, 1, 1, 16'h0020, 0);
        add(0, 3'b011, 1, 8'h11, 3'b010, 3'b010, 1, 1, 16'h0020, 0);
        add(0, 3'b011, 1, 8'h11, 3'b010, 3'b010, 1, 1, 16'h0020, 0);
        add(0, 3'b011, 1, 8'h11, 3'b010, 3'b010, 1, 1, 16'h0020, 0);
        add(0, 3'b011, 1, 8'h11, 3'b001, 3'b010, 1, 1, 16'h0010, 0);
        add(1, 3'b011, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0);
        add(0, 3'b011, 0, 8'h00, 3'b001, 3'b000, 1, 1, 16'h0010, 0);
        add(0, 3'b011, 1, 8'h22, 3'b001, 3'b001, 1, 1, 16'h0010, 0);
        add(0, 3'b010, 1, 8'h22, 3'b010, 3'b001, 1, 1, 16'h0020, 0);
        add(0, 3'b000, 1, 8'h22, 3'b000, 3'b010, 0, 0, 16'h0020, 0);
`endif
        foreach (tab[i]) run_row(tab[i], i);

`ifndef RD_ARB_BURST_EN
        run_row('{1, 3'b000, 0, 8'h00, 3'b000, 3'b000, 0, 0, 16'h0000, 0}, -1);
        ptr = 0;
        last_addr = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) a[i] = 16'($urandom);
            v  = 3'($urandom);
            mv = (ram_q.size() > 0) && ($urandom_range(0, 2) != 0);
            md = mv ? ram_q[0] : 8'($urandom);
            rst             = 1'b0;
            bus.req_addr_i  = {a[2], a[1], a[0]};
            bus.req_valid_i = v;
            bus.mem_valid_i = mv;
            bus.mem_data_i  = md;
            pop  = mv && (tq.size() > 0);
            can  = (tq.size() < 4) || pop;
            win  = -1;
            for (int k = 0; k < 3; k++)
                if (win < 0 && v[(ptr + k) % 3]) win = (ptr + k) % 3;
            g    = can && (win >= 0);
            erdy = g ? 3'(1 << win) : 3'b000;
            ersp = pop ? 3'(1 << tq[0]) : 3'b000;
            #1;
            chk("rnd ready", 32'(bus.req_ready_o), 32'(erdy));
            chk("rnd rsp_valid", 32'(bus.rsp_valid_o), 32'(ersp));
            chk("rnd rsp_data", 32'(bus.rsp_data_o), 32'(md));
            @(posedge clk);
            #1;
            if (pop) begin
                void'(tq.pop_front());
                void'(ram_q.pop_front());
            end
            if (g) begin
                tq.push_back(win);
                ram_q.push_back(a[win][7:0] ^ 8'h5A);
                ptr = (win + 1) % 3;
                last_addr = a[win];
            end
            chk("rnd pending", 32'(pending), 32'(tq.size()));
            chk("rnd mem_en", 32'(bus.mem_en_o), 32'(g));
            chk("rnd mem_addr", 32'(bus.mem_addr_o), 32'(last_addr));
            chk("rnd err", 32'(err), 32'd0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
